// File: rtl/mm_dma.sv
// mm_dma: word-copy DMA engine with a 16-byte slave register window and a
// valid/ready bus-initiator port; raises a level interrupt when a copy ends.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   select, wstrb,      slave access: window select, byte strobes (0 = read),
//   addr, data_i        byte offset, write data
//   ready, data_o       slave completion pulse and read data
//   m_valid, m_addr,    master request, word address, write data,
//   m_wdata, m_wstrb    strobes (4'hF write / 4'h0 read)
//   m_ready, m_rdata    master accept / read data
//   irq                 level interrupt, done && irq_en (registered)
//
// Register map (word offsets): 0x0 SRC, 0x4 DST, 0x8 LEN,
//   0xC CTRL {b5 aborted, b4 abort, b3 irq_en, b2 done, b1 busy, b0 start}.
// Optional feature macro: MM_DMA_ABORT_EN enables CTRL abort/aborted.
module mm_dma #(
    parameter int LEN_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        select,
    input  logic [3:0]  wstrb,
    input  logic [3:0]  addr,
    input  logic [31:0] data_i,
    output logic        ready,
    output logic [31:0] data_o,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        irq
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_RGAP, S_WR, S_WGAP, S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                 r_sel_q;
    logic                 r_ready;
    logic [31:0]          r_data_o;
    logic [31:0]          r_src;
    logic [31:0]          r_dst;
    logic [31:0]          r_buf;
    logic [LEN_WIDTH-1:0] r_len;
    logic                 r_done;
    logic                 r_irq_en;
    logic                 r_irq;

    logic        w_sel_rise;
    logic        w_wr;
    logic        w_ctrl_wr;
    logic        w_busy;
    logic        w_start;
    logic        w_abort_pend;
    logic        w_aborted;
    logic [1:0]  w_idx;
    logic [31:0] w_rdval;
    logic        w_unused;

    // One access per rising edge of select; ready follows a cycle later.
    assign w_sel_rise = select & ~r_sel_q;
    assign w_wr       = w_sel_rise & (wstrb != 4'h0);
    assign w_idx      = addr[3:2];
    assign w_ctrl_wr  = w_wr & (w_idx == 2'd3);
    assign w_busy     = (r_state == S_RD) || (r_state == S_RGAP) ||
                        (r_state == S_WR) || (r_state == S_WGAP);
    assign w_start    = w_ctrl_wr & data_i[0] & (r_state == S_IDLE);
    assign w_unused   = ^{addr[1:0], data_i[1]};

`ifdef MM_DMA_ABORT_EN
    logic r_abort_req;
    logic r_aborted;

    // Abort is only honoured at a gap state, so an open beat always finishes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_abort_req <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            if (w_start)
                r_aborted <= 1'b0;
            if (w_ctrl_wr && data_i[4] && w_busy)
                r_abort_req <= 1'b1;
            if (r_state == S_DONE) begin
                r_abort_req <= 1'b0;
                if (r_abort_req)
                    r_aborted <= 1'b1;
            end
        end
    end

    assign w_abort_pend = r_abort_req;
    assign w_aborted    = r_aborted;
`else
    assign w_abort_pend = 1'b0;
    assign w_aborted    = 1'b0;
`endif

    always_comb begin
        w_rdval = 32'h0;
        case (w_idx)
            2'd0: w_rdval = r_src;
            2'd1: w_rdval = r_dst;
            2'd2: w_rdval = {{(32-LEN_WIDTH){1'b0}}, r_len};
            default: w_rdval = {26'h0, w_aborted, 1'b0,
                                r_irq_en, r_done, w_busy, 1'b0};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start && r_len != '0) w_next = S_RD;
            S_RD:   if (m_ready) w_next = S_RGAP;
            S_RGAP: w_next = w_abort_pend ? S_DONE : S_WR;
            S_WR:   if (m_ready) w_next = S_WGAP;
            // r_len already holds the post-beat count here.
            S_WGAP: w_next = (w_abort_pend || r_len == '0) ? S_DONE : S_RD;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Reset forces m_valid low at once, even with a beat outstanding.
    always_comb begin
        m_valid = 1'b0;
        m_addr  = 32'h0;
        m_wdata = 32'h0;
        m_wstrb = 4'h0;
        case (r_state)
            S_RD: begin
                m_valid = ~reset;
                m_addr  = r_src;
            end
            S_WR: begin
                m_valid = ~reset;
                m_addr  = r_dst;
                m_wdata = r_buf;
                m_wstrb = 4'hF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_q  <= 1'b0;
            r_ready  <= 1'b0;
            r_data_o <= 32'h0;
            r_src    <= 32'h0;
            r_dst    <= 32'h0;
            r_buf    <= 32'h0;
            r_len    <= '0;
            r_done   <= 1'b0;
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_sel_q  <= select;
            r_ready  <= w_sel_rise;
            r_data_o <= (w_sel_rise && wstrb == 4'h0) ? w_rdval : 32'h0;
            if (w_wr && !w_busy) begin
                case (w_idx)
                    2'd0: r_src <= {data_i[31:2], 2'b00};
                    2'd1: r_dst <= {data_i[31:2], 2'b00};
                    2'd2: r_len <= data_i[LEN_WIDTH-1:0];
                    default: ;
                endcase
            end
            if (w_ctrl_wr) begin
                r_irq_en <= data_i[3];
                if (data_i[2])
                    r_done <= 1'b0;
            end
            // Completion set follows the W1C so it wins on a collision.
            if (w_start && r_len == '0)
                r_done <= 1'b1;
            if (r_state == S_DONE)
                r_done <= 1'b1;
            if (r_state == S_RD && m_ready)
                r_buf <= m_rdata;
            if (r_state == S_WR && m_ready) begin
                r_src <= r_src + 32'd4;
                r_dst <= r_dst + 32'd4;
                r_len <= r_len - 1'b1;
            end
            r_irq <= r_done & r_irq_en;
        end
    end

    assign ready  = r_ready;
    assign data_o = r_data_o;
    assign irq    = r_irq;

endmodule

// File: tb/tb_mm_dma.sv
// tb_mm_dma: scoreboard bench for mm_dma; expected bus beats and register
// reads are queued by the stimulus and checked by separate monitors.
module tb_mm_dma;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        select = 1'b0;
    logic [3:0]  wstrb = 4'h0;
    logic [3:0]  addr = 4'h0;
    logic [31:0] data_i = 32'h0;
    logic        ready;
    logic [31:0] data_o;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic        irq;

    mm_dma #(.LEN_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .select(select), .wstrb(wstrb),
        .addr(addr), .data_i(data_i), .ready(ready), .data_o(data_o),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
    } bexp_t;

    typedef struct {
        logic [31:0] e;
        logic [31:0] m;
        string       n;
    } rexp_t;

    int total = 0;
    int bad = 0;
    bexp_t bq[$];
    rexp_t rq[$];
    bexp_t be;
    rexp_t re;
    logic [31:0] mem [logic [31:0]];
    int waits = 0;
    int wcnt = 0;
    int n_wr = 0;
    int n_valid = 0;
    logic [31:0] s_a, s_d;
    logic [3:0]  s_s;
    bit stable;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", n, act, exp);
        end
    endtask

    function automatic logic [31:0] memrd(input logic [31:0] a);
        if (mem.exists(a))
            return mem[a];
        return 32'hDEAD0000 ^ a;
    endfunction

    function automatic logic [31:0] pat(input logic [31:0] seed, input int i);
        return seed ^ (32'h01030507 * 32'(i));
    endfunction

    // Bus responder and bus scoreboard monitor.
    always @(negedge clk) begin
        if (m_valid)
            n_valid++;
        if (m_ready) begin
            m_ready = 1'b0;
        end else if (m_valid) begin
            if (wcnt == 0) begin
                s_a = m_addr; s_d = m_wdata; s_s = m_wstrb; stable = 1'b1;
            end else if ({m_addr, m_wdata, m_wstrb} !== {s_a, s_d, s_s}) begin
                stable = 1'b0;
            end
            if (wcnt >= waits) begin
                if (wcnt > 0)
                    chk("bus_stable", 32'(stable), 32'd1);
                total++;
                if (bq.size() == 0) begin
                    bad++;
                    $display("FAIL bus_unexpected got=%08h/%h exp=none",
                             m_addr, m_wstrb);
                end else begin
                    be = bq.pop_front();
                    if (m_addr !== be.a || m_wstrb !== be.s ||
                        (be.s == 4'hF && m_wdata !== be.d)) begin
                        bad++;
                        $display("FAIL bus_beat got=%08h/%h/%08h exp=%08h/%h/%08h",
                                 m_addr, m_wstrb, m_wdata, be.a, be.s, be.d);
                    end
                end
                if (m_wstrb == 4'hF) begin
                    mem[m_addr] = m_wdata;
                    n_wr++;
                end else begin
                    m_rdata = memrd(m_addr);
                end
                m_ready = 1'b1;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Slave read monitor.
    always @(negedge clk) begin
        if (ready && wstrb == 4'h0) begin
            if (rq.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_unexpected got=%08h exp=none", data_o);
            end else begin
                re = rq.pop_front();
                if (re.m != 32'h0)
                    chk(re.n, data_o & re.m, re.e & re.m);
            end
        end
    end

    task automatic cpu(input logic [3:0] a, input logic [3:0] s,
                       input logic [31:0] d, output logic [31:0] q);
        bit got = 1'b0;
        @(negedge clk);
        select = 1'b1; addr = a; wstrb = s; data_i = d;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = ready;
        end
        q = data_o;
        select = 1'b0;
        if (!got) begin
            total++; bad++;
            $display("FAIL slave_timeout got=none exp=ready addr=%h", a);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] q;
        cpu(a, 4'hF, d, q);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e,
                      input string n);
        logic [31:0] q;
        rq.push_back('{e, 32'hFFFFFFFF, n});
        cpu(a, 4'h0, 32'h0, q);
    endtask

    task automatic poll(input logic [3:0] a, output logic [31:0] q);
        rq.push_back('{32'h0, 32'h0, ""});
        cpu(a, 4'h0, 32'h0, q);
    endtask

    task automatic wait_done();
        logic [31:0] q;
        for (int i = 0; i < 300; i++) begin
            poll(4'hC, q);
            if (q[2])
                return;
        end
        total++; bad++;
        $display("FAIL done_timeout got=not_done exp=done");
    endtask

    task automatic push_copy(input logic [31:0] src, input logic [31:0] dst,
                             input int n, input logic [31:0] seed);
        for (int i = 0; i < n; i++) begin
            mem[src + 32'(4*i)] = pat(seed, i);
            bq.push_back({src + 32'(4*i), 4'h0, 32'h0});
            bq.push_back({dst + 32'(4*i), 4'hF, pat(seed, i)});
        end
    endtask

    task automatic check_copy(input logic [31:0] dst, input int n,
                              input logic [31:0] seed, input string nm);
        for (int i = 0; i < n; i++)
            chk(nm, memrd(dst + 32'(4*i)), pat(seed, i));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int v0;
        int base;
        int nw;
        repeat (3) @(negedge clk);
        chk("rst_outs", {27'h0, ready, m_valid, irq, m_wstrb[1:0]}, 32'h0);
        chk("rst_maddr", m_addr, 32'h0);
        chk("rst_wdata_do", m_wdata | data_o, 32'h0);
        reset = 1'b0;
        rd(4'h0, 32'h0, "rst_src");
        rd(4'h8, 32'h0, "rst_len");
        rd(4'hC, 32'h0, "rst_ctrl");

        // basic 4-word copy
        wr(4'h0, 32'h100); wr(4'h4, 32'h200); wr(4'h8, 32'd4);
        push_copy(32'h100, 32'h200, 4, 32'hA5A50000);
        wr(4'hC, 32'h1);
        rd(4'hC, 32'h2, "t1_busy");
        wait_done();
        check_copy(32'h200, 4, 32'hA5A50000, "t1_copy");
        rd(4'h8, 32'h0, "t1_len");
        rd(4'h0, 32'h110, "t1_src");
        rd(4'h4, 32'h210, "t1_dst");
        rd(4'hC, 32'h4, "t1_ctrl");

        // interrupt on a 1-word copy, then W1C of done
        wr(4'h0, 32'h140); wr(4'h4, 32'h300); wr(4'h8, 32'd1);
        push_copy(32'h140, 32'h300, 1, 32'h5EED0001);
        wr(4'hC, 32'hD);
        wait_done();
        chk("t2_irq_set", 32'(irq), 32'd1);
        check_copy(32'h300, 1, 32'h5EED0001, "t2_copy");
        wr(4'hC, 32'hC);
        @(negedge clk);
        chk("t2_irq_clr", 32'(irq), 32'd0);
        rd(4'hC, 32'h8, "t2_ctrl");

        // wait states, plus writes and start while busy
        waits = 3;
        wr(4'h0, 32'h400); wr(4'h4, 32'h500); wr(4'h8, 32'd3);
        push_copy(32'h400, 32'h500, 3, 32'h13570000);
        wr(4'hC, 32'h5);
        wr(4'h8, 32'd9); wr(4'h0, 32'h999); wr(4'h4, 32'h777);
        wr(4'hC, 32'h1);
        rd(4'hC, 32'h2, "t3_busy");
        wait_done();
        check_copy(32'h500, 3, 32'h13570000, "t3_copy");
        rd(4'h8, 32'h0, "t3_len");
        rd(4'h0, 32'h40C, "t3_src");
        rd(4'h4, 32'h50C, "t3_dst");
        waits = 0;

        // zero length start
        wr(4'hC, 32'h4);
        wr(4'h8, 32'd0);
        rd(4'hC, 32'h0, "t4_clr");
        v0 = n_valid;
        wr(4'hC, 32'h1);
        rd(4'hC, 32'h4, "t4_done");
        chk("t4_no_valid", 32'(n_valid - v0), 32'd0);

        // address wrap
        wr(4'h0, 32'hFFFFFFFC); wr(4'h4, 32'h600); wr(4'h8, 32'd2);
        push_copy(32'hFFFFFFFC, 32'h600, 2, 32'h0BADF00D);
        wr(4'hC, 32'h5);
        wait_done();
        check_copy(32'h600, 2, 32'h0BADF00D, "t5_copy");
        rd(4'h0, 32'h4, "t5_src_wrap");
        rd(4'h4, 32'h608, "t5_dst");

        // reset while a read beat is outstanding
        waits = 20;
        wr(4'h0, 32'h100); wr(4'h4, 32'h700); wr(4'h8, 32'd4);
        wr(4'hC, 32'h5);
        for (int i = 0; i < 20 && !m_valid; i++)
            @(negedge clk);
        chk("t5_in_rd", {27'h0, m_valid, m_wstrb}, 32'h10);
        reset = 1'b1;
        #1;
        chk("t5_rst_valid_now", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("t5_rst_bus", {m_addr[30:0], m_valid}, 32'h0);
        reset = 1'b0;
        waits = 0;
        rd(4'h0, 32'h0, "t5_rst_src");
        rd(4'h4, 32'h0, "t5_rst_dst");
        rd(4'h8, 32'h0, "t5_rst_len");
        rd(4'hC, 32'h0, "t5_rst_ctrl");

`ifdef MM_DMA_ABORT_EN
        waits = 2;
        base = n_wr;
        wr(4'h0, 32'h100); wr(4'h4, 32'h800); wr(4'h8, 32'd8);
        push_copy(32'h100, 32'h800, 8, 32'h77770000);
        wr(4'hC, 32'h5);
        for (int i = 0; i < 200 && n_wr < base + 1; i++)
            @(negedge clk);
        wr(4'hC, 32'h10);
        wait_done();
        nw = n_wr - base;
        chk("t6_partial", 32'(nw < 8 && nw >= 1), 32'd1);
        rd(4'h8, 32'(8 - nw), "t6_len");
        rd(4'h0, 32'h100 + 32'(4*nw), "t6_src");
        rd(4'h4, 32'h800 + 32'(4*nw), "t6_dst");
        rd(4'hC, 32'h24, "t6_ctrl");
        check_copy(32'h800, nw, 32'h77770000, "t6_copy");
        repeat (4) @(negedge clk);
        bq.delete();
        waits = 0;
`else
        base = n_wr;
        wr(4'h0, 32'h100); wr(4'h4, 32'h800); wr(4'h8, 32'd3);
        push_copy(32'h100, 32'h800, 3, 32'h77770000);
        wr(4'hC, 32'h5);
        wr(4'hC, 32'h10);
        wait_done();
        nw = n_wr - base;
        chk("t6_full", 32'(nw), 32'd3);
        rd(4'h8, 32'h0, "t6_len");
        rd(4'hC, 32'h4, "t6_ctrl");
        check_copy(32'h800, 3, 32'h77770000, "t6_copy");
`endif

        repeat (5) @(negedge clk);
        chk("bq_drained", 32'(bq.size()), 32'd0);
        chk("rq_drained", 32'(rq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
